change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream of VendingMachine; pays out refund/change as physical coins.
//  - Accepts one refund amount per request.
//  - Breaks it greedily into 10/5/1 coins.
//  - Hands the hopper mechanism one coin at a time over a valid/ack handshake.
//  - Reports completion, and any unpaid shortfall if a coin tube runs empty.
// PARAMETERS
//  AMT_W     6   width of amounts and coin values (max 63)
//  COIN_HI   10  largest denomination
//  COIN_MID  5   middle denomination
//  COIN_LO   1   smallest denomination
//  INV_W     4   width of each per-denomination inventory counter
//  INIT_INV  8   coins loaded in each tube at reset
// PORTS
//  clk            in   1      system clock; all logic on rising edge
//  reset          in   1      synchronous, active-low reset
//  refund_valid   in   1      refund request present
//  refund_amount  in   AMT_W  amount to pay out; sampled on accept
//  refund_ready   out  1      high only in IDLE; accept = valid & ready
//  eject_coin     out  AMT_W  denomination being ejected; 0 when idle
//  eject_valid    out  1      coin request to hopper
//  eject_ack      in   1      hopper has dropped the coin
//  done           out  1      one-cycle pulse: refund finished
//  short          out  1      with done: amount not fully paid
//  shortfall      out  AMT_W  with done: unpaid remainder, else 0
//  busy           out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset values (reset==0 at an edge):
//   - state=IDLE, refund_ready=1, eject_valid=0, eject_coin=0.
//   - done=0, short=0, shortfall=0, busy=0.
//   - remaining=0; all tubes reloaded to INIT_INV.
//   - Reset wins over any other event, including mid-EJECT; a pending coin is abandoned.
//  FSM (registered outputs): IDLE -> SELECT -> EJECT -> (SELECT | DONE) -> IDLE.
//  IDLE:
//   - On accept, latch remaining=refund_amount.
//   - Amount 0 -> DONE; otherwise -> SELECT.
//   - refund_valid while not ready is ignored, not queued.
//  SELECT:
//   - d = largest of HI/MID/LO with d<=remaining and its tube count>0.
//   - If d exists: eject_coin=d, eject_valid=1 -> EJECT.
//   - If none: -> DONE with short=1, shortfall=remaining.
//  EJECT:
//   - Hold eject_coin and eject_valid stable until eject_ack (any number of stall cycles).
//   - On ack: remaining-=d, tube[d]-=1, eject_valid=0, eject_coin=0.
//   - Then: new remaining==0 -> DONE, else -> SELECT.
//   - eject_ack outside EJECT is ignored.
//  DONE:
//   - done=1 for exactly one cycle; short and shortfall are valid only then.
//   - -> IDLE; refund_ready=1 in the following cycle.
//  Timing and arithmetic:
//   - Each coin costs at least 2 cycles (SELECT + EJECT with same-cycle ack).
//   - remaining never underflows, because d<=remaining is checked.
//   - A tube at 0 is never decremented.
// CONFIGURATION
//  CHANGE_INV_EN defined:
//   - Tube counters are implemented and checked as described above.
//   - short/shortfall operate normally.
//  CHANGE_INV_EN undefined:
//   - No counters; every tube is treated as non-empty.
//   - short and shortfall are tied to 0; payout is always exact.
// TESTING
//  1. reset=0 for 2 cycles mid-traffic -> refund_ready=1, eject_valid=0, done=0, busy=0.
//  2. refund 26, ack same cycle -> eject_coin sequence 10,10,5,1; done pulses 1 cycle; short=0.
//  3. refund 0 -> done=1 the cycle after accept; no eject_valid ever; shortfall=0.
//  4. refund 15, ack withheld 3 cycles -> eject_coin=10 and eject_valid held all 3 cycles; then 5; done.
//  5. CHANGE_INV_EN, INIT_INV=1, refund 26 -> ejects 10,5,1; done with short=1, shortfall=10.
//  6. reset=0 during EJECT -> next cycle eject_valid=0, state IDLE, tubes back to INIT_INV.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy 10/5/1 change payout to a coin hopper over a valid/ack handshake.
// Define CHANGE_INV_EN to model per-tube coin inventory and report shortfall.
module change_dispenser #(
    parameter int unsigned AMT_W    = 6,
    parameter int unsigned COIN_HI  = 10,
    parameter int unsigned COIN_MID = 5,
    parameter int unsigned COIN_LO  = 1,
    parameter int unsigned INV_W    = 4,
    parameter int unsigned INIT_INV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refund_valid,
    input  logic [AMT_W-1:0] refund_amount,
    output logic             refund_ready,
    output logic [AMT_W-1:0] eject_coin,
    output logic             eject_valid,
    input  logic             eject_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] shortfall,
    output logic             busy
);

    localparam logic [AMT_W-1:0] HI  = AMT_W'(COIN_HI);
    localparam logic [AMT_W-1:0] MID = AMT_W'(COIN_MID);
    localparam logic [AMT_W-1:0] LO  = AMT_W'(COIN_LO);

    // The reload count must fit in a tube counter.
    if (INIT_INV >= (64'd1 << INV_W)) begin : g_bad_inv
        $error("INIT_INV does not fit in INV_W bits");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       avail_c;
    logic             sel_found_c;
    logic [AMT_W-1:0] sel_coin_c;

`ifdef CHANGE_INV_EN
    logic [INV_W-1:0] tube_hi;
    logic [INV_W-1:0] tube_mid;
    logic [INV_W-1:0] tube_lo;

    assign avail_c = {tube_hi != '0, tube_mid != '0, tube_lo != '0};
`else
    assign avail_c   = 3'b111;
    assign short     = 1'b0;
    assign shortfall = '0;
`endif

    // Largest stocked denomination that does not exceed what is still owed.
    always_comb begin
        sel_found_c = 1'b0;
        sel_coin_c  = '0;
        if (avail_c[2] && (HI <= remaining)) begin
            sel_found_c = 1'b1;
            sel_coin_c  = HI;
        end else if (avail_c[1] && (MID <= remaining)) begin
            sel_found_c = 1'b1;
            sel_coin_c  = MID;
        end else if (avail_c[0] && (LO <= remaining)) begin
            sel_found_c = 1'b1;
            sel_coin_c  = LO;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            refund_ready <= 1'b1;
            eject_valid  <= 1'b0;
            eject_coin   <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            remaining    <= '0;
`ifdef CHANGE_INV_EN
            short        <= 1'b0;
            shortfall    <= '0;
            tube_hi      <= INV_W'(INIT_INV);
            tube_mid     <= INV_W'(INIT_INV);
            tube_lo      <= INV_W'(INIT_INV);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (refund_valid) begin
                        remaining    <= refund_amount;
                        refund_ready <= 1'b0;
                        busy         <= 1'b1;
                        if (refund_amount == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (sel_found_c) begin
                        eject_coin  <= sel_coin_c;
                        eject_valid <= 1'b1;
                        state       <= S_EJECT;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
`ifdef CHANGE_INV_EN
                        short     <= 1'b1;
                        shortfall <= remaining;
`endif
                    end
                end
                S_EJECT: begin
                    if (eject_ack) begin
                        remaining   <= remaining - eject_coin;
                        eject_valid <= 1'b0;
                        eject_coin  <= '0;
`ifdef CHANGE_INV_EN
                        if ((eject_coin == HI) && (tube_hi != '0)) begin
                            tube_hi <= tube_hi - INV_W'(1);
                        end else if ((eject_coin == MID) && (tube_mid != '0)) begin
                            tube_mid <= tube_mid - INV_W'(1);
                        end else if ((eject_coin == LO) && (tube_lo != '0)) begin
                            tube_lo <= tube_lo - INV_W'(1);
                        end
`endif
                        if (remaining == eject_coin) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_DONE: begin
                    done         <= 1'b0;
                    refund_ready <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
`ifdef CHANGE_INV_EN
                    short        <= 1'b0;
                    shortfall    <= '0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, handshake stalls, reset, inventory.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       refund_valid = 1'b0;
    logic [5:0] refund_amount = '0;
    logic       eject_ack = 1'b0;

    logic       ready1, ev1, done1, short1, busy1;
    logic [5:0] coin1, sf1;

    logic       m_ready, m_ev, m_done, m_short, m_busy;
    logic [5:0] m_coin, m_sf;
    bit         use_inv = 1'b0;

    int errors = 0;
    int checks = 0;
    int coins[$];
    int obs[$];
    int done_cyc;
    logic       r_short;
    logic [5:0] r_sf;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .refund_valid (refund_valid),
        .refund_amount(refund_amount),
        .refund_ready (ready1),
        .eject_coin   (coin1),
        .eject_valid  (ev1),
        .eject_ack    (eject_ack),
        .done         (done1),
        .short        (short1),
        .shortfall    (sf1),
        .busy         (busy1)
    );

`ifdef CHANGE_INV_EN
    logic       refund_valid2 = 1'b0;
    logic       ready2, ev2, done2, short2, busy2;
    logic [5:0] coin2, sf2;

    change_dispenser #(.INIT_INV(1)) dut_inv (
        .clk          (clk),
        .reset        (reset),
        .refund_valid (refund_valid2),
        .refund_amount(refund_amount),
        .refund_ready (ready2),
        .eject_coin   (coin2),
        .eject_valid  (ev2),
        .eject_ack    (eject_ack),
        .done         (done2),
        .short        (short2),
        .shortfall    (sf2),
        .busy         (busy2)
    );

    assign m_ready = use_inv ? ready2 : ready1;
    assign m_ev    = use_inv ? ev2    : ev1;
    assign m_done  = use_inv ? done2  : done1;
    assign m_short = use_inv ? short2 : short1;
    assign m_busy  = use_inv ? busy2  : busy1;
    assign m_coin  = use_inv ? coin2  : coin1;
    assign m_sf    = use_inv ? sf2    : sf1;
`else
    assign m_ready = ready1;
    assign m_ev    = ev1;
    assign m_done  = done1;
    assign m_short = short1;
    assign m_busy  = busy1;
    assign m_coin  = coin1;
    assign m_sf    = sf1;
`endif

    function automatic string fmt(input int q[$]);
        string s = "";
        foreach (q[i]) begin
            if (i != 0) s = {s, " "};
            s = {s, $sformatf("%0d", q[i])};
        end
        return s;
    endfunction

    task automatic set_valid(input bit v);
`ifdef CHANGE_INV_EN
        if (use_inv) refund_valid2 = v;
        else refund_valid = v;
`else
        refund_valid = v;
`endif
    endtask

    // Issue one refund, ack each coin after `stall` wait cycles, record until done.
    task automatic run_refund(input int amt, input int stall, input bit noise);
        int cnt = 0;
        bit got_done = 1'b0;
        coins.delete();
        obs.delete();
        done_cyc = -1;
        r_short  = 1'b0;
        r_sf     = '0;
        @(negedge clk);
        refund_amount = 6'(amt);
        eject_ack = 1'b0;
        set_valid(1'b1);
        for (int c = 1; c <= 300 && !got_done; c++) begin
            @(negedge clk);
            if (noise) begin
                refund_amount = 6'd33;
                set_valid(1'b1);
            end else begin
                set_valid(1'b0);
            end
            eject_ack = 1'b0;
            if (m_ev) begin
                obs.push_back(int'(m_coin));
                if (cnt == stall) begin
                    eject_ack = 1'b1;
                    coins.push_back(int'(m_coin));
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            if (m_done) begin
                got_done = 1'b1;
                done_cyc = c;
                r_short  = m_short;
                r_sf     = m_sf;
            end
        end
        set_valid(1'b0);
        eject_ack = 1'b0;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout amount=%0d: done never seen", amt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", m_ready); end
        checks++; if (m_ev !== 1'b0)    begin errors++; $display("FAIL rst_eject_valid got=%b exp=0", m_ev); end
        checks++; if (m_coin !== 6'd0)  begin errors++; $display("FAIL rst_eject_coin got=%0d exp=0", m_coin); end
        checks++; if (m_done !== 1'b0)  begin errors++; $display("FAIL rst_done got=%b exp=0", m_done); end
        checks++; if (m_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b exp=0", m_busy); end
        checks++; if (m_sf !== 6'd0 || m_short !== 1'b0) begin
            errors++; $display("FAIL rst_short got=%b/%0d exp=0/0", m_short, m_sf);
        end
        reset = 1'b1;
    endtask

    task automatic check_after_done(input string tag);
        @(negedge clk);
        checks++;
        if (m_done !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_post_done done/ready/busy got=%b%b%b exp=011", tag, m_done, m_ready, m_busy);
        end
    endtask

    task automatic test_change_26();
        run_refund(26, 0, 1'b0);
        checks++; if (fmt(coins) != "10 10 5 1") begin errors++; $display("FAIL c26_coins got='%s' exp='10 10 5 1'", fmt(coins)); end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL c26_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (r_short !== 1'b0 || r_sf !== 6'd0) begin errors++; $display("FAIL c26_short got=%b/%0d exp=0/0", r_short, r_sf); end
        check_after_done("c26");
    endtask

    task automatic test_zero();
        run_refund(0, 0, 1'b0);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL zero_no_eject got=%0d coins exp=0", obs.size()); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
        checks++; if (r_sf !== 6'd0 || r_short !== 1'b0) begin errors++; $display("FAIL zero_short got=%b/%0d exp=0/0", r_short, r_sf); end
        check_after_done("zero");
    endtask

    task automatic test_stall_15();
        run_refund(15, 3, 1'b0);
        checks++; if (fmt(obs) != "10 10 10 10 5 5 5 5") begin errors++; $display("FAIL stall_hold got='%s' exp='10 10 10 10 5 5 5 5'", fmt(obs)); end
        checks++; if (fmt(coins) != "10 5") begin errors++; $display("FAIL stall_coins got='%s' exp='10 5'", fmt(coins)); end
        checks++; if (done_cyc != 11) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=11", done_cyc); end
        check_after_done("stall");
    endtask

    task automatic test_ignore_busy();
        run_refund(7, 2, 1'b1);
        checks++; if (fmt(coins) != "5 1 1") begin errors++; $display("FAIL busy_ignore_coins got='%s' exp='5 1 1'", fmt(coins)); end
        check_after_done("busy_ignore");
        repeat (2) @(negedge clk);
        checks++; if (m_busy !== 1'b0 || m_ev !== 1'b0) begin errors++; $display("FAIL busy_ignore_queued busy/ev got=%b%b exp=00", m_busy, m_ev); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        @(negedge clk);
        refund_amount = 6'd26;
        set_valid(1'b1);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            set_valid(1'b0);
            if (m_ev) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_reach_eject got=0 exp=1"); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ev !== 1'b0 || m_coin !== 6'd0 || m_ready !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset ev/coin/ready/busy/done got=%b/%0d/%b/%b/%b exp=0/0/1/0/0", m_ev, m_coin, m_ready, m_busy, m_done);
        end
        @(negedge clk);
        reset = 1'b1;
        run_refund(26, 0, 1'b0);
        checks++; if (fmt(coins) != "10 10 5 1") begin errors++; $display("FAIL mid_after_coins got='%s' exp='10 10 5 1'", fmt(coins)); end
        check_after_done("mid");
    endtask

    task automatic test_max_63();
        run_refund(63, 0, 1'b0);
        checks++; if (fmt(coins) != "10 10 10 10 10 10 1 1 1") begin errors++; $display("FAIL max63_coins got='%s' exp='10 10 10 10 10 10 1 1 1'", fmt(coins)); end
        checks++; if (r_short !== 1'b0 || r_sf !== 6'd0) begin errors++; $display("FAIL max63_short got=%b/%0d exp=0/0", r_short, r_sf); end
        check_after_done("max63");
    endtask

`ifdef CHANGE_INV_EN
    task automatic test_inventory();
        use_inv = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            run_refund(26, 0, 1'b0);
            checks++; if (fmt(coins) != "10 5 1") begin errors++; $display("FAIL inv_coins pass%0d got='%s' exp='10 5 1'", pass, fmt(coins)); end
            checks++; if (r_short !== 1'b1 || r_sf !== 6'd10) begin errors++; $display("FAIL inv_short pass%0d got=%b/%0d exp=1/10", pass, r_short, r_sf); end
            check_after_done("inv");
            reset = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
        end
        use_inv = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_change_26();
        test_zero();
        test_stall_15();
        test_ignore_busy();
        test_reset_mid();
        test_max_63();
`ifdef CHANGE_INV_EN
        test_inventory();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
